// File: rtl/bridge_pkg.sv
// Shared constants, address map and state type for the bridge command mailbox.
// Used by bridge_cmd_mailbox and bridge_mailbox_regs.
package bridge_pkg;

   localparam logic [15:0] CMD_MAGIC      = 16'h434D;
   localparam logic [15:0] STATUS_OK      = 16'h6F6B;
   localparam logic [15:0] STATUS_BUSY    = 16'h6275;
   localparam logic [15:0] RESULT_TIMEOUT = 16'hFFFF;

   localparam int          NUM_WORDS  = 8;
   localparam logic [7:0]  OFF_CMD    = 8'h00;
   localparam logic [7:0]  OFF_PARAM  = 8'h20;
   localparam logic [7:0]  OFF_RESP   = 8'h40;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } mailbox_state_e;

   // Word-aligned offsets inside the 32-byte PARAM / RESP windows only.
   function automatic logic is_param_off(input logic [7:0] off);
      return (off[7:5] == OFF_PARAM[7:5]) && (off[1:0] == 2'b00);
   endfunction

   function automatic logic is_resp_off(input logic [7:0] off);
      return (off[7:5] == OFF_RESP[7:5]) && (off[1:0] == 2'b00);
   endfunction

   function automatic logic [2:0] word_idx(input logic [7:0] off);
      return off[4:2];
   endfunction

endpackage

// File: rtl/bridge_driver_if.sv
// Transaction interface between the command mailbox (driver) and bridge_cmd (handler).
interface bridge_driver_if;

   logic             clk;
   logic             valid;
   logic [15:0]      word;
   logic [7:0][31:0] param;
   logic             done;
   logic [15:0]      result;
   logic [7:0][31:0] response;

   modport driver (
      output clk, valid, word, param,
      input  done, result, response
   );

   modport handler (
      input  clk, valid, word, param,
      output done, result, response
   );

endinterface

// File: rtl/bridge_mailbox_regs.sv
// PARAM/RESP register file of the command mailbox plus its registered read mux.
module bridge_mailbox_regs
   import bridge_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic                       rd_en,
   input  logic [7:0]                 offset,
   input  logic [31:0]                wr_data,
   input  logic                       param_wr_allow,
   input  logic                       resp_load,
   input  logic                       resp_clear,
   input  logic [NUM_WORDS-1:0][31:0] resp_in,
   input  logic [31:0]                status_val,
   output logic [NUM_WORDS-1:0][31:0] param_out,
   output logic [31:0]                rd_data
);

   logic [31:0] param_q [NUM_WORDS];
   logic [31:0] param_d [NUM_WORDS];
   logic [31:0] resp_q  [NUM_WORDS];
   logic [31:0] resp_d  [NUM_WORDS];
   logic [31:0] rd_data_q, rd_data_d;
   logic        param_hit;

   assign param_hit = wr_en && param_wr_allow && is_param_off(offset);

   for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign param_d[gi]   = (param_hit && (word_idx(offset) == 3'(gi))) ? wr_data : param_q[gi];
      assign resp_d[gi]    = resp_clear ? 32'h0 :
                             resp_load  ? resp_in[gi] : resp_q[gi];
      assign param_out[gi] = param_q[gi];
   end

   // Reads sample the registers before any same-cycle write lands.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         if (offset == OFF_CMD) begin
            rd_data_d = status_val;
         end else if (is_param_off(offset)) begin
            rd_data_d = param_q[word_idx(offset)];
         end else if (is_resp_off(offset)) begin
            rd_data_d = resp_q[word_idx(offset)];
         end else begin
            rd_data_d = 32'h0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            param_q[i] <= 32'h0;
            resp_q[i]  <= 32'h0;
         end
         rd_data_q <= 32'h0;
      end else begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            param_q[i] <= param_d[i];
            resp_q[i]  <= resp_d[i];
         end
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/bridge_cmd_mailbox.sv
// Host command mailbox: decodes bridge writes, issues one bridge_cmd transaction per command.
// Optional WAIT watchdog enabled by defining BRIDGE_CMD_MAILBOX_TIMEOUT_EN.
module bridge_cmd_mailbox
   import bridge_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'hF800_0000,
   parameter int unsigned TIMEOUT_CYCLES = 2**24
)(
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     bridge_addr,
   input  logic            bridge_wr,
   input  logic [31:0]     bridge_wr_data,
   input  logic            bridge_rd,
   output logic [31:0]     bridge_rd_data,
   bridge_driver_if.driver cmd,
   output logic            overrun
);

   mailbox_state_e             state_q, state_d;
   logic [15:0]                word_q, word_d;
   logic [NUM_WORDS-1:0][31:0] snap_q, snap_d;
   logic [15:0]                result_q, result_d;
   logic                       overrun_q, overrun_d;

   logic                       in_win;
   logic [7:0]                 offset;
   logic                       wr_hit;
   logic                       rd_hit;
   logic                       cmd_wr;
   logic                       busy;
   logic                       resp_load;
   logic                       resp_clear;
   logic                       timeout_hit;
   logic [31:0]                status_val;
   logic [NUM_WORDS-1:0][31:0] param_words;

   assign in_win = (bridge_addr[31:8] == BASE_ADDR[31:8]);
   assign offset = bridge_addr[7:0];
   assign wr_hit = bridge_wr && in_win;
   assign rd_hit = bridge_rd && in_win;
   assign cmd_wr = wr_hit && (offset == OFF_CMD) && (bridge_wr_data[31:16] == CMD_MAGIC);
   assign busy   = (state_q == ISSUE) || (state_q == WAIT);

`ifdef BRIDGE_CMD_MAILBOX_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;

   // ISSUE always precedes WAIT, so clearing there zeroes the count on WAIT entry.
   always_comb begin
      wdog_cnt_d = wdog_cnt_q;
      if (state_q == ISSUE) begin
         wdog_cnt_d = '0;
      end else if (state_q == WAIT) begin
         wdog_cnt_d = wdog_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_cnt_q <= '0;
      end else begin
         wdog_cnt_q <= wdog_cnt_d;
      end
   end

   assign timeout_hit = (state_q == WAIT) && (wdog_cnt_q == CNT_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      snap_d     = snap_q;
      result_d   = result_q;
      overrun_d  = overrun_q;
      resp_load  = 1'b0;
      resp_clear = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (cmd_wr) begin
               state_d = ISSUE;
               word_d  = bridge_wr_data[15:0];
               snap_d  = param_words;
            end
         end
         ISSUE: begin
            state_d = WAIT;
            if (cmd_wr) overrun_d = 1'b1;
         end
         WAIT: begin
            if (cmd_wr) overrun_d = 1'b1;
            if (cmd.done) begin
               result_d  = cmd.result;
               resp_load = 1'b1;
               state_d   = DONE;
            end else if (timeout_hit) begin
               result_d   = RESULT_TIMEOUT;
               resp_clear = 1'b1;
               state_d    = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         word_q    <= 16'h0;
         snap_q    <= '0;
         result_q  <= 16'h0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         snap_q    <= snap_d;
         result_q  <= result_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      status_val = 32'h0;
      unique case (state_q)
         ISSUE, WAIT: status_val = {STATUS_BUSY, word_q};
         DONE:        status_val = {STATUS_OK, result_q};
         default:     status_val = 32'h0;
      endcase
   end

   bridge_mailbox_regs u_regs (
      .clk            (clk),
      .reset          (reset),
      .wr_en          (wr_hit),
      .rd_en          (rd_hit),
      .offset         (offset),
      .wr_data        (bridge_wr_data),
      .param_wr_allow (!busy),
      .resp_load      (resp_load),
      .resp_clear     (resp_clear),
      .resp_in        (cmd.response),
      .status_val     (status_val),
      .param_out      (param_words),
      .rd_data        (bridge_rd_data)
   );

   assign cmd.clk   = clk;
   assign cmd.valid = (state_q == ISSUE);
   assign cmd.word  = word_q;
   assign cmd.param = snap_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_bridge_cmd_mailbox.sv
// Randomized bench for bridge_cmd_mailbox against a transaction-level mailbox model.
`timescale 1ns/1ps
module tb_bridge_cmd_mailbox;

   localparam logic [31:0] BASE = 32'hF800_0000;
   localparam int          TMO  = 16;
`ifdef BRIDGE_CMD_MAILBOX_TIMEOUT_EN
   localparam bit          TMO_EN = 1'b1;
`else
   localparam bit          TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] bridge_addr = 32'h0;
   logic        bridge_wr = 1'b0;
   logic [31:0] bridge_wr_data = 32'h0;
   logic        bridge_rd = 1'b0;
   logic [31:0] bridge_rd_data;
   logic        overrun;

   bridge_driver_if cmd_if ();

   bridge_cmd_mailbox #(
      .BASE_ADDR      (BASE),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .bridge_addr    (bridge_addr),
      .bridge_wr      (bridge_wr),
      .bridge_wr_data (bridge_wr_data),
      .bridge_rd      (bridge_rd),
      .bridge_rd_data (bridge_rd_data),
      .cmd            (cmd_if),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   // Model: register contents, what the host would read, and the age of the
   // outstanding command (cycles since acceptance, -1 when none is outstanding).
   logic [31:0] m_param [8];
   logic [31:0] m_resp  [8];
   logic [31:0] m_snap  [8];
   logic [15:0] m_word;
   logic [31:0] m_status;
   logic [31:0] m_rd;
   logic        m_overrun;
   int          m_age;
   int          n_cmp = 0;
   int          n_err = 0;
   bit          chk_en = 1'b0;

   task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [7:0] off);
      int o;
      o = int'(off);
      if (o == 0) return m_status;
      if (o >= 32 && o <= 60 && (o % 4) == 0) return m_param[(o - 32) / 4];
      if (o >= 64 && o <= 92 && (o % 4) == 0) return m_resp[(o - 64) / 4];
      return 32'h0;
   endfunction

   task automatic complete(input logic [15:0] res, input logic [255:0] resp);
      m_status = {16'h6F6B, res};
      for (int i = 0; i < 8; i++) m_resp[i] = resp[i*32 +: 32];
      m_age = -1;
      $display("txn word=%h result=%h resp2=%h", m_word, res, resp[95:64]);
   endtask

   // Advances the model across the coming clock edge using the driven inputs.
   task automatic model_update();
      bit         busy, win, accepted;
      logic [7:0] off;
      int         o;
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            m_param[i] = 32'h0; m_resp[i] = 32'h0; m_snap[i] = 32'h0;
         end
         m_word = 16'h0; m_status = 32'h0; m_rd = 32'h0; m_overrun = 1'b0; m_age = -1;
         return;
      end
      win      = (bridge_addr & 32'hFFFF_FF00) == BASE;
      off      = bridge_addr[7:0];
      o        = int'(off);
      busy     = (m_age >= 1);
      accepted = 1'b0;
      if (bridge_rd && win) m_rd = model_read(off);
      if (bridge_wr && win) begin
         if (o == 0) begin
            if (bridge_wr_data[31:16] == 16'h434D) begin
               if (busy) begin
                  m_overrun = 1'b1;
               end else begin
                  accepted = 1'b1;
                  m_word   = bridge_wr_data[15:0];
                  for (int i = 0; i < 8; i++) m_snap[i] = m_param[i];
                  m_status = {16'h6275, bridge_wr_data[15:0]};
               end
            end
         end else if (o >= 32 && o <= 60 && (o % 4) == 0 && !busy) begin
            m_param[(o - 32) / 4] = bridge_wr_data;
         end
      end
      if (busy) begin
         if (m_age >= 2 && cmd_if.done) complete(cmd_if.result, cmd_if.response);
         else if (TMO_EN && m_age >= 2 && (m_age - 1) == TMO) complete(16'hFFFF, 256'h0);
         else m_age++;
      end else if (accepted) begin
         m_age = 1;
      end
   endtask

   task automatic check_outputs();
      logic [255:0] exp_p;
      for (int i = 0; i < 8; i++) exp_p[i*32 +: 32] = m_snap[i];
      cmp("valid",   256'(cmd_if.valid),   256'(m_age == 1));
      cmp("word",    256'(cmd_if.word),    256'(m_word));
      cmp("param",   256'(cmd_if.param),   exp_p);
      cmp("overrun", 256'(overrun),        256'(m_overrun));
      cmp("rd_data", 256'(bridge_rd_data), 256'(m_rd));
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) check_outputs();
   end

   task automatic step();
      model_update();
      @(negedge clk);
      bridge_wr   = 1'b0;
      bridge_rd   = 1'b0;
      cmd_if.done = 1'b0;
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] data);
      bridge_addr    = BASE | {24'h0, off};
      bridge_wr      = 1'b1;
      bridge_wr_data = data;
      step();
   endtask

   task automatic rd_chk(input logic [7:0] off, input logic [31:0] exp, input string name);
      bridge_addr = BASE | {24'h0, off};
      bridge_rd   = 1'b1;
      step();
      cmp(name, 256'(bridge_rd_data), 256'(exp));
   endtask

   task automatic pulse_done(input logic [15:0] res, input logic [31:0] r2);
      cmd_if.done   = 1'b1;
      cmd_if.result = res;
      for (int i = 0; i < 8; i++) cmd_if.response[i] = $urandom;
      cmd_if.response[2] = r2;
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   function automatic logic [7:0] pick_off();
      int k;
      k = $urandom_range(0, 11);
      if (k == 0) return 8'h00;
      if (k <= 4) return 8'(32 + 4 * $urandom_range(0, 7));
      if (k <= 8) return 8'(64 + 4 * $urandom_range(0, 7));
      if (k == 9) return 8'h04;
      if (k == 10) return 8'h60;
      return 8'h21;
   endfunction

   initial begin
      cmd_if.done     = 1'b0;
      cmd_if.result   = 16'h0;
      cmd_if.response = '0;
      reset = 1'b1;
      model_update();
      chk_en = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // Reset state and bad magic
      rd_chk(8'h00, 32'h0, "status_after_reset");
      wr(8'h00, 32'hDEAD_0001);
      cmp("valid_bad_magic", 256'(cmd_if.valid), 256'(1'b0));
      rd_chk(8'h00, 32'h0, "status_bad_magic");

      // Basic command with parameter snapshot
      wr(8'h20, 32'h1234_5678);
      wr(8'h00, 32'h434D_0082);
      cmp("valid_issue", 256'(cmd_if.valid), 256'(1'b1));
      cmp("word_issue", 256'(cmd_if.word), 256'(16'h0082));
      cmp("param0_issue", 256'(cmd_if.param[0]), 256'(32'h1234_5678));
      step();
      cmp("valid_one_cycle", 256'(cmd_if.valid), 256'(1'b0));
      rd_chk(8'h00, 32'h6275_0082, "status_busy");
      wr(8'h00, 32'h434D_0099);
      cmp("overrun_set", 256'(overrun), 256'(1'b1));
      wr(8'h20, 32'hFFFF_FFFF);
      cmp("param0_stable", 256'(cmd_if.param[0]), 256'(32'h1234_5678));
      cmp("word_stable", 256'(cmd_if.word), 256'(16'h0082));
      pulse_done(16'h0002, 32'hCAFE_0000);
      rd_chk(8'h00, 32'h6F6B_0002, "status_ok");
      rd_chk(8'h48, 32'hCAFE_0000, "resp2");
      rd_chk(8'h20, 32'h1234_5678, "param0_ignored_write");
      cmp("overrun_sticky", 256'(overrun), 256'(1'b1));

      // Reset during WAIT, then a clean command
      wr(8'h20, 32'hAAAA_5555);
      wr(8'h00, 32'h434D_0011);
      step();
      step();
      do_reset();
      cmp("valid_after_reset", 256'(cmd_if.valid), 256'(1'b0));
      cmp("overrun_after_reset", 256'(overrun), 256'(1'b0));
      cmp("param_after_reset", 256'(cmd_if.param), 256'(0));
      rd_chk(8'h00, 32'h0, "status_reset_wait");
      rd_chk(8'h20, 32'h0, "param0_reset_wait");
      rd_chk(8'h48, 32'h0, "resp2_reset_wait");
      wr(8'h00, 32'h434D_0022);
      step();
      pulse_done(16'h0033, 32'h0BAD_F00D);
      rd_chk(8'h00, 32'h6F6B_0033, "status_after_recover");

      // Randomized traffic
      for (int c = 0; c < 2500; c++) begin
         int          op;
         logic [7:0]  off;
         logic [15:0] hi;
         op  = $urandom_range(0, 99);
         off = pick_off();
         reset = ($urandom_range(0, 399) == 0);
         cmd_if.result = 16'($urandom);
         for (int i = 0; i < 8; i++) cmd_if.response[i] = $urandom;
         if (m_age >= 1) cmd_if.done = ($urandom_range(0, 3) == 0) || (m_age >= 10);
         else cmd_if.done = ($urandom_range(0, 7) == 0);
         if (op < 20) begin
            bridge_addr = BASE | 32'(32 + 4 * $urandom_range(0, 7));
            bridge_wr = 1'b1; bridge_wr_data = $urandom;
         end else if (op < 30) begin
            bridge_addr = BASE; bridge_wr = 1'b1;
            bridge_wr_data = {16'h434D, 16'($urandom)};
         end else if (op < 35 && m_age < 1) begin
            hi = 16'($urandom);
            if (hi == 16'h434D) hi = 16'h0;
            bridge_addr = BASE; bridge_wr = 1'b1; bridge_wr_data = {hi, 16'($urandom)};
         end else if (op < 75) begin
            bridge_addr = BASE | {24'h0, off}; bridge_rd = 1'b1;
         end else if (op < 85) begin
            bridge_addr = BASE | {24'h0, off}; bridge_rd = 1'b1; bridge_wr = 1'b1;
            bridge_wr_data = (off == 8'h00) ? {16'h434D, 16'($urandom)} : $urandom;
         end
         step();
         reset = 1'b0;
      end

`ifdef BRIDGE_CMD_MAILBOX_TIMEOUT_EN
      // Watchdog: leave any outstanding command, then let one time out
      for (int i = 0; i < 40 && m_age >= 1; i++) begin
         cmd_if.done = 1'b1;
         step();
      end
      wr(8'h00, 32'h434D_0044);
      step();
      pulse_done(16'h0044, 32'h1111_2222);
      rd_chk(8'h48, 32'h1111_2222, "resp2_before_timeout");
      wr(8'h00, 32'h434D_0055);
      repeat (15) step();
      rd_chk(8'h00, 32'h6275_0055, "status_wait15");
      rd_chk(8'h00, 32'h6275_0055, "status_wait16");
      rd_chk(8'h00, 32'h6F6B_FFFF, "status_timeout");
      rd_chk(8'h48, 32'h0, "resp2_timeout_cleared");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
